// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/XOR/NAND unit between N_REQ clients.
// Each grant captures the winner's operands, produces one result and holds gnt until the winner releases req.
module gate_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       op,
  input  logic [WIDTH*N_REQ-1:0]   a,
  input  logic [WIDTH*N_REQ-1:0]   b,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         y,
  output logic                     y_valid,
  output logic                     busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [IW-1:0]     rr_ptr_r;
  logic [IW-1:0]     win_r;
  logic [1:0]        op_l_r;
  logic [WIDTH-1:0]  a_l_r;
  logic [WIDTH-1:0]  b_l_r;
  logic [IW-1:0]     win_s;
  logic              win_found_s;
  logic [IW:0]       idx_sum_s;
  logic [IW-1:0]     idx_s;

  function automatic logic [WIDTH-1:0] gate_f(input logic [1:0] opc,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
    case (opc)
      2'b00:   gate_f = x & z;
      2'b01:   gate_f = x | z;
      2'b10:   gate_f = x ^ z;
      2'b11:   gate_f = ~(x & z);
      default: gate_f = {WIDTH{1'b0}};
    endcase
  endfunction

  // Winner search: first set req bit at or after rr_ptr, wrapping upward.
  always_comb begin
    win_s       = {IW{1'b0}};
    win_found_s = 1'b0;
    idx_sum_s   = {(IW+1){1'b0}};
    idx_s       = {IW{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      idx_sum_s = {1'b0, rr_ptr_r} + (IW+1)'(k);
      if (idx_sum_s >= (IW+1)'(N_REQ)) begin
        idx_sum_s = idx_sum_s - (IW+1)'(N_REQ);
      end else begin
        idx_sum_s = idx_sum_s;
      end
      idx_s = idx_sum_s[IW-1:0];
      if (!win_found_s && req[idx_s]) begin
        win_found_s = 1'b1;
        win_s       = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) state_s = EXEC;
        else             state_s = IDLE;
      end
      EXEC:    state_s = RESP;
      RESP:    state_s = RELEASE;
      RELEASE: begin
        if (!req[win_r]) state_s = IDLE;
        else             state_s = RELEASE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, operand capture, result and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      rr_ptr_r <= {IW{1'b0}};
      win_r    <= {IW{1'b0}};
      op_l_r   <= 2'b00;
      a_l_r    <= {WIDTH{1'b0}};
      b_l_r    <= {WIDTH{1'b0}};
      gnt      <= {N_REQ{1'b0}};
      y        <= {WIDTH{1'b0}};
      y_valid  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
      y_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            win_r  <= win_s;
            op_l_r <= op[win_s*2 +: 2];
            a_l_r  <= a[win_s*WIDTH +: WIDTH];
            b_l_r  <= b[win_s*WIDTH +: WIDTH];
          end
        end
        EXEC: begin
          y       <= gate_f(op_l_r, a_l_r, b_l_r);
          y_valid <= 1'b1;
          gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_r;
        end
        RESP: begin
          if (win_r == IW'(N_REQ-1)) rr_ptr_r <= {IW{1'b0}};
          else                       rr_ptr_r <= win_r + {{(IW-1){1'b0}}, 1'b1};
        end
        RELEASE: begin
          if (!req[win_r]) gnt <= {N_REQ{1'b0}};
        end
        default: begin
          gnt <= {N_REQ{1'b0}};
        end
      endcase
    end
  end

endmodule
